redundancy_expander: RTL and testbench

Decompression end of the lifm redundancy path. The block accepts compressed lowered-ifm columns together with per-row mapping-table distances and rebuilds the full `MAX_R_SIZE`-word lifm column. A redundant word is recovered from a history buffer of previously reconstructed columns. The block sits between the compressed lifm buffer and the PE-array feeder, with valid/ready handshakes on both sides and one column per cycle throughput.

---
 rtl/redundancy_expander.sv | 120 ++++++++++++
 tb/tb_redundancy_expander.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/redundancy_expander.sv
// redundancy_expander
//   Rebuilds full lifm columns from compressed columns plus per-row
//   mapping-table distances. A non-zero distance d pulls the word of the
//   same row from the column reconstructed d columns earlier in the frame.
//   One column per cycle, single output register stage.
//
// Ports
//   clk, reset              clock, synchronous active-high reset
//   in_valid / in_ready     compressed column handshake
//   in_first                column starts a new lowered-ifm frame
//   lifm_comp               compressed column, row r at [r*WORD_WIDTH +: WORD_WIDTH]
//   mt_comp                 per-row distance, row r at [r*DIST_WIDTH +: DIST_WIDTH]
//   out_valid / out_ready   reconstructed column handshake
//   lifm_line               reconstructed column, same row packing
//   out_col                 column index within frame (mod MAX_C_SIZE)
//   err / err_clr           sticky bad-reference flag and its clear
module redundancy_expander #(
  parameter int WORD_WIDTH = 8,
  parameter int DIST_WIDTH = 7,
  parameter int MAX_R_SIZE = 4,
  parameter int MAX_C_SIZE = 128
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic                             in_first,
  input  logic [MAX_R_SIZE*WORD_WIDTH-1:0] lifm_comp,
  input  logic [MAX_R_SIZE*DIST_WIDTH-1:0] mt_comp,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [MAX_R_SIZE*WORD_WIDTH-1:0] lifm_line,
  output logic [DIST_WIDTH-1:0]            out_col,
  output logic                             err,
  input  logic                             err_clr
);

  localparam int LINE_W = MAX_R_SIZE * WORD_WIDTH;
  localparam logic [DIST_WIDTH-1:0] FILL_MAX = DIST_WIDTH'(MAX_C_SIZE - 1);

  // History of reconstructed columns; not reset, reachability is gated by filled.
  logic [WORD_WIDTH-1:0] hist [MAX_C_SIZE][MAX_R_SIZE];

  logic [DIST_WIDTH-1:0] col_cnt;
  logic [DIST_WIDTH-1:0] filled;
  logic [DIST_WIDTH-1:0] cur_col;
  logic [DIST_WIDTH-1:0] cur_fill;
  logic                  accept;
  logic [LINE_W-1:0]     recon;
  logic [MAX_R_SIZE-1:0] row_err;

  // History depth is a power of two, so modular slot arithmetic is just
  // DIST_WIDTH-bit wrap-around subtraction.
  function automatic logic [DIST_WIDTH-1:0] slot(input logic [DIST_WIDTH-1:0] c,
                                                input logic [DIST_WIDTH-1:0] d);
    return c - d;
  endfunction

  always_comb begin
    in_ready = !reset && (!out_valid || out_ready);
    accept   = in_valid && in_ready;
    // in_first restarts the frame in the same beat.
    cur_col  = in_first ? '0 : col_cnt;
    cur_fill = in_first ? '0 : filled;
  end

  always_comb begin
    recon   = '0;
    row_err = '0;
    for (int r = 0; r < MAX_R_SIZE; r++) begin
      if (mt_comp[r*DIST_WIDTH +: DIST_WIDTH] == '0) begin
        recon[r*WORD_WIDTH +: WORD_WIDTH] = lifm_comp[r*WORD_WIDTH +: WORD_WIDTH];
      end else if (mt_comp[r*DIST_WIDTH +: DIST_WIDTH] <= cur_fill) begin
        recon[r*WORD_WIDTH +: WORD_WIDTH] =
          hist[slot(cur_col, mt_comp[r*DIST_WIDTH +: DIST_WIDTH])][r];
      end else begin
        // Reference before frame start: emit zero and flag it.
        row_err[r] = 1'b1;
      end
    end
  end

  // d >= 1 guarantees the read slot differs from the write slot, so the
  // combinational read always sees data from earlier beats only.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int r = 0; r < MAX_R_SIZE; r++) begin
        hist[cur_col][r] <= recon[r*WORD_WIDTH +: WORD_WIDTH];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      col_cnt   <= '0;
      filled    <= '0;
      out_valid <= 1'b0;
      lifm_line <= '0;
      out_col   <= '0;
      err       <= 1'b0;
    end else begin
      if (accept) begin
        col_cnt   <= cur_col + DIST_WIDTH'(1);
        filled    <= (cur_fill == FILL_MAX) ? cur_fill : cur_fill + DIST_WIDTH'(1);
        out_valid <= 1'b1;
        lifm_line <= recon;
        out_col   <= cur_col;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      // A fresh error outranks a simultaneous clear.
      if (accept && |row_err) begin
        err <= 1'b1;
      end else if (err_clr) begin
        err <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_redundancy_expander.sv
// Testbench for redundancy_expander: directed scenarios plus random traffic,
// checked by a frame-list reference model and an output scoreboard.
module tb_redundancy_expander;

  localparam int W = 8;
  localparam int D = 7;
  localparam int R = 4;
  localparam int C = 128;

  logic           clk = 1'b0;
  logic           reset;
  logic           in_valid;
  logic           in_ready;
  logic           in_first;
  logic [R*W-1:0] lifm_comp;
  logic [R*D-1:0] mt_comp;
  logic           out_valid;
  logic           out_ready;
  logic [R*W-1:0] lifm_line;
  logic [D-1:0]   out_col;
  logic           err;
  logic           err_clr;

  redundancy_expander #(
    .WORD_WIDTH(W), .DIST_WIDTH(D), .MAX_R_SIZE(R), .MAX_C_SIZE(C)
  ) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_first(in_first), .lifm_comp(lifm_comp), .mt_comp(mt_comp),
    .out_valid(out_valid), .out_ready(out_ready), .lifm_line(lifm_line),
    .out_col(out_col), .err(err), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [R*W-1:0] line;
    logic [D-1:0]   col;
  } exp_t;

  exp_t           scb[$];
  logic [R*W-1:0] frame[$];   // every column reconstructed so far in this frame
  logic           exp_ov  = 1'b0;
  logic           exp_err = 1'b0;
  int             n_checks = 0;
  int             n_fail   = 0;
  logic           rand_mode = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: sees the same inputs as the DUT, predicts handshake,
  // sticky error and the reconstructed column from the frame list.
  always @(negedge clk) begin : model
    logic           exp_ir;
    logic           acc;
    logic           ill;
    logic [R*W-1:0] w;
    logic [R*W-1:0] src;
    int             len;
    int             d;
    exp_ir = !reset && (!exp_ov || out_ready);
    chk("in_ready", in_ready, exp_ir);
    chk("out_valid", out_valid, exp_ov);
    chk("err", err, exp_err);
    if (reset) begin
      exp_ov  = 1'b0;
      exp_err = 1'b0;
      frame.delete();
      scb.delete();
    end else begin
      acc = in_valid && exp_ir;
      ill = 1'b0;
      if (acc) begin
        if (in_first) frame.delete();
        len = frame.size();
        w   = '0;
        for (int r = 0; r < R; r++) begin
          d = int'(mt_comp[r*D +: D]);
          if (d == 0) begin
            w[r*W +: W] = lifm_comp[r*W +: W];
          end else if (d <= len) begin
            src = frame[len-d];
            w[r*W +: W] = src[r*W +: W];
          end else begin
            ill = 1'b1;
          end
        end
        frame.push_back(w);
        scb.push_back('{line: w, col: D'(len % C)});
      end
      exp_err = ill ? 1'b1 : (err_clr ? 1'b0 : exp_err);
      exp_ov  = acc ? 1'b1 : (out_ready ? 1'b0 : exp_ov);
    end
  end

  // Monitor: every downstream transfer pops and checks the oldest expectation.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (!reset && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (scb.size() == 0) begin
        chk("scb_underflow", 64'd1, 64'd0);
      end else begin
        e = scb.pop_front();
        chk("lifm_line", lifm_line, e.line);
        chk("out_col", out_col, e.col);
      end
    end
  end

  // Random backpressure and error clears during the random phase.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_mode) begin
        out_ready = ($urandom_range(0, 3) != 0);
        err_clr   = ($urandom_range(0, 15) == 0);
      end
    end
  end

  task automatic send(input logic first, input logic [R*W-1:0] comp, input logic [R*D-1:0] mt);
    bit done = 0;
    in_valid  = 1'b1;
    in_first  = first;
    lifm_comp = comp;
    mt_comp   = mt;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (in_ready) done = 1;
      @(posedge clk);
      #1;
    end
    if (!done) chk("send_timeout", 64'd1, 64'd0);
    in_valid = 1'b0;
    in_first = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    logic [R*D-1:0] mt;
    logic [W-1:0]   k8;
    reset = 1'b1; in_valid = 1'b1; in_first = 1'b0; lifm_comp = 32'hDEADBEEF;
    mt_comp = '0; out_ready = 1'b1; err_clr = 1'b0;

    // Reset held two cycles with a pending input.
    repeat (2) begin
      @(negedge clk);
      chk("rst_in_ready", in_ready, 1'b0);
      chk("rst_out_valid", out_valid, 1'b0);
    end
    @(posedge clk); #1;
    reset = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("post_rst_out_valid", out_valid, 1'b0);
    chk("post_rst_line", lifm_line, 32'h0);
    chk("post_rst_err", err, 1'b0);
    chk("post_rst_in_ready", in_ready, 1'b1);
    @(posedge clk); #1;

    // Pass-through and redundancy.
    send(1'b1, 32'h04030201, '0);
    @(negedge clk);
    chk("pass_line", lifm_line, 32'h04030201);
    chk("pass_col", out_col, 7'd0);
    @(posedge clk); #1;
    send(1'b0, 32'h08070605, {7'd1, 7'd0, 7'd0, 7'd1});
    @(negedge clk);
    chk("redund1_line", lifm_line, 32'h04070601);
    chk("redund1_col", out_col, 7'd1);
    @(posedge clk); #1;
    send(1'b0, 32'h0C0B0A09, {7'd0, 7'd0, 7'd2, 7'd0});
    @(negedge clk);
    chk("redund2_line", lifm_line, 32'h0C0B0209);
    chk("redund2_col", out_col, 7'd2);
    @(posedge clk); #1;

    // Backpressure: three stalled cycles with a waiting input.
    send(1'b0, 32'h11223344, '0);
    out_ready = 1'b0;
    fork
      begin
        send(1'b0, 32'h55667788, {7'd0, 7'd1, 7'd0, 7'd0});
        send(1'b0, 32'h99AABBCC, {7'd2, 7'd0, 7'd0, 7'd1});
      end
      begin
        repeat (3) begin
          @(negedge clk);
          chk("stall_in_ready", in_ready, 1'b0);
          chk("stall_line", lifm_line, 32'h11223344);
          chk("stall_col", out_col, 7'd3);
          @(posedge clk); #1;
        end
        out_ready = 1'b1;
      end
    join
    idle(2);

    // Illegal reference at frame start, sticky error, clear, clear vs error.
    send(1'b1, 32'hAABBCCDD, {7'd0, 7'd1, 7'd0, 7'd0});
    @(negedge clk);
    chk("illegal_line", lifm_line, 32'hAA00CCDD);
    chk("illegal_col", out_col, 7'd0);
    chk("illegal_err", err, 1'b1);
    idle(3);
    @(negedge clk);
    chk("err_sticky", err, 1'b1);
    @(posedge clk); #1;
    err_clr = 1'b1;
    idle(1);
    err_clr = 1'b0;
    @(negedge clk);
    chk("err_cleared", err, 1'b0);
    @(posedge clk); #1;
    err_clr = 1'b1;
    send(1'b0, 32'h01020304, {7'd0, 7'd0, 7'd0, 7'd127});
    err_clr = 1'b0;
    @(negedge clk);
    chk("err_wins_clr", err, 1'b1);
    @(posedge clk); #1;
    err_clr = 1'b1;
    idle(1);
    err_clr = 1'b0;

    // Wrap: 130 columns then a max-distance reference.
    for (int k = 0; k < 130; k++) begin
      k8 = W'(k);
      send(k == 0, {k8, k8, k8, k8}, '0);
    end
    send(1'b0, 32'hFFFFFFFF, {7'd127, 7'd127, 7'd127, 7'd127});
    @(negedge clk);
    chk("wrap_line", lifm_line, 32'h03030303);
    chk("wrap_col", out_col, 7'd2);
    chk("wrap_err", err, 1'b0);
    @(posedge clk); #1;

    // Random traffic with random backpressure and clears.
    rand_mode = 1'b1;
    for (int n = 0; n < 400; n++) begin
      for (int r = 0; r < R; r++) begin
        mt[r*D +: D] = ($urandom_range(0, 2) == 0) ? D'(0) : D'($urandom_range(1, 12));
      end
      if ($urandom_range(0, 7) == 0) idle($urandom_range(1, 3));
      send($urandom_range(0, 39) == 0, $urandom, mt);
    end
    rand_mode = 1'b0;
    out_ready = 1'b1;
    err_clr   = 1'b0;
    idle(5);
    @(negedge clk);
    chk("scb_drained", 64'(scb.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
